// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
//   Shared definitions for the cache <-> memory block bus. Used by the cache
//   (initiator) and by mem_bus_responder (memory side).
//   Contents: beat/tag widths, the two legal request tags, block geometry
//   and the responder state encoding.
// ----------------------------------------------------------------------------
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 64;
  localparam int BUS_TAG_WIDTH  = 13;

  localparam logic [BUS_TAG_WIDTH-1:0] MEM_READ  = 13'h0001;
  localparam logic [BUS_TAG_WIDTH-1:0] MEM_WRITE = 13'h0002;

  localparam int BLOCK_BYTES = 64;
  localparam int BLOCK_BEATS = BLOCK_BYTES / (BUS_DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATENCY = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_RESP = 3'd4
  } resp_state_e;

  // Critical-word-first offset inside a block: wraps at the block size.
  function automatic logic [2:0] wrap_offset(input logic [2:0] word,
                                             input logic [2:0] beat);
    return word + beat;
  endfunction

endpackage : bus_pkg

// File: rtl/mem_bus_responder_mem_array.sv
// ----------------------------------------------------------------------------
// mem_array
//   Single-port word array: synchronous write, combinational read on the
//   same address. Contents have no reset, so they survive a responder reset.
//   Ports:
//     clk_i    clock
//     we_i     write enable (write on rising edge)
//     addr_i   word address (read and write)
//     wdata_i  write data
//     rdata_o  read data, combinational from addr_i
// ----------------------------------------------------------------------------
module mem_array #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4096
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port; deliberately not reset so data outlives a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule : mem_array

// File: rtl/mem_bus_responder.sv
// ----------------------------------------------------------------------------
// mem_bus_responder
//   Memory-side responder for the cache block bus. Accepts one block request
//   at a time, acknowledges it, then either streams a block of read beats
//   (critical word first) or absorbs a block of write beats and returns a
//   completion carrying the block base address.
//   Ports:
//     clk          clock, rising edge
//     reset        asynchronous active-low reset
//     bus_reqcyc   request header / write beat valid
//     bus_req      address (header) or write data (data beat)
//     bus_reqtag   MEM_READ / MEM_WRITE on a header
//     bus_reqack   one-cycle accept pulse for a header or data beat
//     bus_respcyc  response beat valid
//     bus_resp     read data or write-completion base address
//     bus_resptag  MEM_READ / MEM_WRITE
//     bus_respack  initiator consumed the current response beat
//     busy         responder not idle
//     tag_err      sticky unknown-tag flag, cleared only by reset
// ----------------------------------------------------------------------------
module mem_bus_responder #(
  parameter int DATA_WIDTH   = bus_pkg::BUS_DATA_WIDTH,
  parameter int TAG_WIDTH    = bus_pkg::BUS_TAG_WIDTH,
  parameter int BLOCK_BEATS  = bus_pkg::BLOCK_BEATS,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_reqcyc,
  input  logic [DATA_WIDTH-1:0] bus_req,
  input  logic [TAG_WIDTH-1:0]  bus_reqtag,
  output logic                  bus_reqack,
  output logic                  bus_respcyc,
  output logic [DATA_WIDTH-1:0] bus_resp,
  output logic [TAG_WIDTH-1:0]  bus_resptag,
  input  logic                  bus_respack,
  output logic                  busy,
  output logic                  tag_err
);

  import bus_pkg::*;

  localparam int BEAT_W = $clog2(BLOCK_BEATS);
  localparam int OFF_W  = BEAT_W + 3;            // byte offset bits in a block
  localparam int AW     = $clog2(MEM_WORDS);
  localparam int BLK_W  = AW - BEAT_W;           // block index bits in the array
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_BEATS - 1);
  localparam logic [7:0]        LAT_INIT  = 8'(READ_LATENCY);
  localparam logic [TAG_WIDTH-1:0] TAG_RD = TAG_WIDTH'(MEM_READ);
  localparam logic [TAG_WIDTH-1:0] TAG_WR = TAG_WIDTH'(MEM_WRITE);

  resp_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] base_q,    base_d;
  logic [BEAT_W-1:0]     word_q,    word_d;
  logic [BEAT_W-1:0]     beat_q,    beat_d;
  logic [7:0]            cnt_q,     cnt_d;
  logic                  reqack_q,  reqack_d;
  logic                  respcyc_q, respcyc_d;
  logic [TAG_WIDTH-1:0]  resptag_q, resptag_d;
  logic                  tagerr_q,  tagerr_d;

  logic                  hdr_take_s;
  logic                  wr_take_s;
  logic                  resp_hs_s;
  logic                  is_rd_s;
  logic                  is_wr_s;
  logic [BEAT_W-1:0]     rd_off_s;
  logic [BLK_W-1:0]      blk_s;
  logic [AW-1:0]         mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;

  // A beat presented while the previous ack is still high is the same beat
  // the initiator has not yet withdrawn, so it is never taken twice.
  assign hdr_take_s = (state_q == ST_IDLE)    && bus_reqcyc && !reqack_q;
  assign wr_take_s  = (state_q == ST_WR_DATA) && bus_reqcyc && !reqack_q;
  assign resp_hs_s  = respcyc_q && bus_respack;
  assign is_rd_s    = (bus_reqtag == TAG_RD);
  assign is_wr_s    = (bus_reqtag == TAG_WR);

  // Base is block aligned, so the block index is a plain bit field and the
  // wrapped offset is concatenated rather than added (aliases modulo depth).
  assign blk_s    = base_q[OFF_W +: BLK_W];
  assign rd_off_s = BEAT_W'(wrap_offset(3'(word_q), 3'(beat_q)));

  // Array address: ascending beats for writes, critical-word-first for reads.
  always_comb begin
    mem_addr_s = {blk_s, rd_off_s};
    if (state_q == ST_WR_DATA) begin
      mem_addr_s = {blk_s, beat_q};
    end else begin
      mem_addr_s = {blk_s, rd_off_s};
    end
  end

  mem_array #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (MEM_WORDS)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_take_s),
    .addr_i  (mem_addr_s),
    .wdata_i (bus_req),
    .rdata_o (mem_rdata_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_take_s && is_rd_s) begin
          state_d = ST_LATENCY;
        end else if (hdr_take_s && is_wr_s) begin
          state_d = ST_WR_DATA;
        end else begin
          state_d = ST_IDLE;       // unknown tags are acked but dropped
        end
      end
      ST_LATENCY: begin
        if (cnt_q <= 8'd1) begin
          state_d = ST_RD_RESP;
        end else begin
          state_d = ST_LATENCY;
        end
      end
      ST_RD_RESP: begin
        if (resp_hs_s && (beat_q == LAST_BEAT)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_RESP;
        end
      end
      ST_WR_DATA: begin
        if (wr_take_s && (beat_q == LAST_BEAT)) begin
          state_d = ST_WR_RESP;
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_RESP: begin
        if (resp_hs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values (all land in registers).
  always_comb begin
    base_d    = base_q;
    word_d    = word_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    reqack_d  = hdr_take_s | wr_take_s;
    tagerr_d  = tagerr_q;
    respcyc_d = 1'b0;
    resptag_d = '0;

    if (hdr_take_s) begin
      base_d   = {bus_req[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      word_d   = bus_req[OFF_W-1:3];
      beat_d   = '0;
      cnt_d    = LAT_INIT;
      tagerr_d = tagerr_q | (!is_rd_s && !is_wr_s);
    end else if (wr_take_s) begin
      beat_d = beat_q + 1'b1;
    end else if ((state_q == ST_RD_RESP) && resp_hs_s) begin
      beat_d = beat_q + 1'b1;      // wraps back to 0 after the last beat
    end else if ((state_q == ST_LATENCY) && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      beat_d = beat_q;
    end

    case (state_d)
      ST_RD_RESP: begin
        respcyc_d = 1'b1;
        resptag_d = TAG_RD;
      end
      ST_WR_RESP: begin
        respcyc_d = 1'b1;
        resptag_d = TAG_WR;
      end
      default: begin
        respcyc_d = 1'b0;
        resptag_d = '0;
      end
    endcase
  end

  // Datapath, handshake and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      word_q    <= '0;
      beat_q    <= '0;
      cnt_q     <= 8'd0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resptag_q <= '0;
      tagerr_q  <= 1'b0;
    end else begin
      base_q    <= base_d;
      word_q    <= word_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resptag_q <= resptag_d;
      tagerr_q  <= tagerr_d;
    end
  end

  // Response data: array word for reads, block base for write completions.
  always_comb begin
    bus_resp = '0;
    case (state_q)
      ST_RD_RESP: bus_resp = mem_rdata_s;
      ST_WR_RESP: bus_resp = base_q;
      default:    bus_resp = '0;
    endcase
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  assign bus_resptag = resptag_q;
  assign busy        = (state_q != ST_IDLE);
  assign tag_err     = tagerr_q;

endmodule : mem_bus_responder

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

  import bus_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        busy;
  logic        tag_err;

  int vectors     = 0;
  int miscompares = 0;

  mem_bus_responder #(
    .DATA_WIDTH   (64),
    .TAG_WIDTH    (13),
    .BLOCK_BEATS  (8),
    .MEM_WORDS    (4096),
    .READ_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack),
    .busy        (busy),
    .tag_err     (tag_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for an ack pulse; called at a negedge, returns at one.
  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus_reqack) begin
        got = 1'b1;
        break;
      end
    end
    check_val("ack_seen", {63'd0, got}, 64'd1);
  endtask

  task automatic send_header(input logic [63:0] addr, input logic [12:0] tag);
    bit got;
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    wait_ack(got);
    bus_reqcyc = 1'b0;
  endtask

  // Collect 8 read beats; expected beat b = dbase + ((start + b) mod 8).
  task automatic collect(input logic [63:0] dbase, input int start,
                         input int stall_beat, input int stall_n,
                         input bit chk_data, input bit chk_lat);
    int waited = 0;
    logic [63:0] e;
    while (!bus_respcyc && waited < 64) begin
      @(negedge clk);
      waited++;
      check_val("no_ack_wait", {63'd0, bus_reqack}, 64'd0);
    end
    if (chk_lat) check_val("rd_latency", 64'(waited), 64'(LAT));
    for (int b = 0; b < 8; b++) begin
      e = dbase + 64'((start + b) % 8);
      check_val("rd_cyc", {63'd0, bus_respcyc}, 64'd1);
      check_val("rd_no_ack", {63'd0, bus_reqack}, 64'd0);
      if (chk_data) begin
        check_val("rd_data", bus_resp, e);
        check_val("rd_tag", {51'd0, bus_resptag}, {51'd0, MEM_READ});
      end
      if (b == stall_beat) begin
        bus_respack = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check_val("stall_cyc", {63'd0, bus_respcyc}, 64'd1);
          check_val("stall_data", bus_resp, e);
        end
        bus_respack = 1'b1;
      end
      @(negedge clk);
    end
    check_val("rd_end_cyc", {63'd0, bus_respcyc}, 64'd0);
  endtask

  task automatic write_block(input logic [63:0] addr, input logic [63:0] dbase);
    bit got;
    int acks = 0;
    send_header(addr, MEM_WRITE);
    if (bus_reqack) acks++;
    for (int i = 0; i < 8; i++) begin
      bus_reqcyc = 1'b1;
      bus_req    = dbase + 64'(i);
      wait_ack(got);
      if (got) acks++;
    end
    bus_reqcyc = 1'b0;
    check_val("wr_acks", 64'(acks), 64'd9);
    check_val("wr_cmp_cyc", {63'd0, bus_respcyc}, 64'd1);
    check_val("wr_cmp_tag", {51'd0, bus_resptag}, {51'd0, MEM_WRITE});
    check_val("wr_cmp_base", bus_resp, {addr[63:6], 6'd0});
    @(negedge clk);
    check_val("wr_end_cyc", {63'd0, bus_respcyc}, 64'd0);
    check_val("wr_end_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    // Reset held with a request pending: nothing accepted, outputs quiet.
    reset       = 1'b0;
    bus_reqcyc  = 1'b1;
    bus_req     = 64'h200;
    bus_reqtag  = MEM_READ;
    bus_respack = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_ack", {63'd0, bus_reqack}, 64'd0);
    check_val("rst_respcyc", {63'd0, bus_respcyc}, 64'd0);
    check_val("rst_resp", bus_resp, 64'd0);
    check_val("rst_resptag", {51'd0, bus_resptag}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_tagerr", {63'd0, tag_err}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_rel_ack", {63'd0, bus_reqack}, 64'd1);
    bus_reqcyc = 1'b0;
    collect(64'd0, 0, -1, 0, 1'b0, 1'b1);

    // Preload 0x200 block, then aligned read with latency check.
    write_block(64'h200, 64'h1000);
    send_header(64'h200, MEM_READ);
    collect(64'h1000, 0, -1, 0, 1'b1, 1'b1);

    // Wrapped read starting at word 5, stalled 3 cycles on beat 2.
    send_header(64'h228, MEM_READ);
    collect(64'h1000, 5, 2, 3, 1'b1, 1'b1);

    // Write then read back another block.
    write_block(64'h1C0, 64'hA0);
    send_header(64'h1C0, MEM_READ);
    collect(64'hA0, 0, -1, 0, 1'b1, 1'b1);

    // Address beyond the array aliases onto block 0x200.
    send_header(64'h8200, MEM_READ);
    collect(64'h1000, 0, -1, 0, 1'b1, 1'b1);

    // Second header held during a read is not accepted until it finishes.
    send_header(64'h1C0, MEM_READ);
    bus_reqcyc = 1'b1;
    bus_req    = 64'h200;
    bus_reqtag = MEM_READ;
    collect(64'hA0, 0, -1, 0, 1'b1, 1'b1);
    check_val("ovl_idle_ack", {63'd0, bus_reqack}, 64'd0);
    check_val("ovl_idle_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check_val("ovl_late_ack", {63'd0, bus_reqack}, 64'd1);
    bus_reqcyc = 1'b0;
    collect(64'h1000, 0, -1, 0, 1'b1, 1'b1);

    // Unknown tag: acked once, sticky error, stays idle.
    bus_reqcyc = 1'b1;
    bus_req    = 64'h0;
    bus_reqtag = 13'h0007;
    @(negedge clk);
    check_val("err_ack", {63'd0, bus_reqack}, 64'd1);
    check_val("err_flag", {63'd0, tag_err}, 64'd1);
    check_val("err_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check_val("err_no_reack", {63'd0, bus_reqack}, 64'd0);
    bus_reqcyc = 1'b0;
    @(negedge clk);
    check_val("err_sticky", {63'd0, tag_err}, 64'd1);

    // Reset in the middle of a write aborts it; array keeps its contents.
    send_header(64'h400, MEM_WRITE);
    for (int i = 0; i < 3; i++) begin
      bus_reqcyc = 1'b1;
      bus_req    = 64'h55 + 64'(i);
      wait_ack(got);
    end
    bus_reqcyc = 1'b0;
    check_val("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check_val("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_val("mid_rst_ack", {63'd0, bus_reqack}, 64'd0);
    check_val("mid_rst_tagerr", {63'd0, tag_err}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_header(64'h200, MEM_READ);
    collect(64'h1000, 0, -1, 0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_bus_responder

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the cache bus protocol. The cache is the initiator and this block answers it.
- Accepts one block request at a time on the request channel and acknowledges it. Returns a 64-byte block as 8 beats on the response channel, or absorbs 8 write beats and returns a completion.
- Backed by an internal word array.
- Used as the main-memory model under the cache in system simulation, and as the memory-controller front end.

Parameters:
- DATA_WIDTH, 64, bus beat width (BUS_DATA_WIDTH).
- TAG_WIDTH, 13, bus tag width (BUS_TAG_WIDTH).
- BLOCK_BEATS, 8, beats per cache block (64 B / 8 B).
- MEM_WORDS, 4096, depth of the backing array in DATA_WIDTH words; power of two.
- READ_LATENCY, 4, cycles from ack to first read beat; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_reqcyc  in  1  initiator has a valid request or write beat on bus_req/bus_reqtag.
- bus_req  in  DATA_WIDTH  request address (header) or write data (data beat).
- bus_reqtag  in  TAG_WIDTH  MEM_READ or MEM_WRITE on the header; ignored on data beats.
- bus_reqack  out  1  one-cycle pulse: header or data beat accepted.
- bus_respcyc  out  1  response beat valid.
- bus_resp  out  DATA_WIDTH  read data, or the block base address for a write completion.
- bus_resptag  out  TAG_WIDTH  MEM_READ or MEM_WRITE.
- bus_respack  in  1  initiator consumed the current response beat.
- busy  out  1  state != IDLE.
- tag_err  out  1  sticky: a header carried an unknown tag; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 and state goes to IDLE.
  - Beat and latency counters clear.
  - Array contents are not cleared and are preserved across reset.
  - A reset mid-transfer aborts the transfer. Write beats already stored remain.
- States: IDLE, LATENCY, RD_RESP, WR_DATA, WR_RESP.
- IDLE:
  - If bus_reqcyc=1 at edge T: latch base = bus_req & ~63, word = bus_req[5:3], tag = bus_reqtag.
  - bus_reqack=1 for exactly cycle T+1.
  - MEM_READ goes to LATENCY with cnt=READ_LATENCY.
  - MEM_WRITE goes to WR_DATA with beat=0.
  - Any other tag: ack it, set tag_err, stay in IDLE.
- Ack rules:
  - bus_reqack is registered and never high two cycles in a row.
  - A request seen in the cycle bus_reqack is high is not re-accepted. The initiator must drop or change bus_reqcyc after the ack.
  - No header is accepted outside IDLE. The block handles one outstanding transaction.
- LATENCY:
  - cnt decrements each cycle.
  - When cnt reaches 1, go to RD_RESP with beat=0. The first bus_respcyc=1 is in cycle T+1+READ_LATENCY.
- RD_RESP:
  - Drive bus_respcyc=1, bus_resptag=MEM_READ, bus_resp=mem[idx].
  - idx = ((base>>3) + ((word+beat) mod BLOCK_BEATS)) mod MEM_WORDS. This is critical-word-first, wrapping within the block.
  - Beat advances on each edge where bus_respcyc & bus_respack.
  - While bus_respack=0, hold the beat and all outputs stable.
  - After the handshake on beat BLOCK_BEATS-1: bus_respcyc=0 next cycle and go to IDLE.
- WR_DATA:
  - For each edge with bus_reqcyc=1 and bus_reqack=0: write bus_req to mem[(base>>3)+beat], pulse bus_reqack, increment beat.
  - Writes are always ascending from base and ignore word.
  - After beat BLOCK_BEATS-1, go to WR_RESP.
- WR_RESP:
  - Drive bus_respcyc=1, bus_resptag=MEM_WRITE, bus_resp=base until bus_respack, then go to IDLE.
- Addresses above MEM_WORDS*8 alias modulo the array. No error is raised.
- A bus_respack with bus_respcyc=0 is ignored.
- Simultaneous final-beat respack and a new bus_reqcyc: the new header is not accepted in that cycle. It is sampled in IDLE on the following edge.
- Array reads are combinational from the registered index. The beat counter is 3 bits and wraps naturally.

Decomposition:
- bus_pkg (shared with cache) holds:
  - BUS_DATA_WIDTH, BUS_TAG_WIDTH, MEM_READ, MEM_WRITE;
  - BLOCK_BYTES=64 and BLOCK_BEATS;
  - the responder state enum.
- One sub-module: mem_array, a single-port word array with synchronous write and combinational read, parameterized by width and depth.
- The FSM, counters and handshake logic stay in mem_bus_responder.

Test Plan:
- Reset: hold reset=0 with bus_reqcyc=1 -> no ack, all outputs 0, busy=0. Release reset -> ack in the second cycle after release.
- Aligned read: preload mem[0x40..0x47] = 0x1000+i (byte address 0x200), issue MEM_READ at 0x200, respack always 1 -> ack at T+1, 8 beats 0x1000..0x1007 starting at T+5, then respcyc=0.
- Wrapped read: MEM_READ at 0x228 -> beats 0x1005,0x1006,0x1007,0x1000..0x1004.
- Backpressure: during that read, hold respack=0 for 3 cycles on beat 2 -> bus_resp stays at beat-2 data with respcyc=1, no beat is lost, total 8 beats.
- Write then read: MEM_WRITE at 0x1C0, data 0xA0..0xA7 -> 9 acks total, completion beat tag=MEM_WRITE resp=0x1C0. A following read of 0x1C0 returns 0xA0..0xA7.
- Error and overlap:
  - Header with tag 0x7 -> ack, tag_err=1, busy=0.
  - A second header asserted during LATENCY -> not acked until the read completes.
